// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode selectors and a constant-foldable log2 helper.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Ceiling log2, usable in parameter/localparam expressions.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_sync_if.sv
// Producer/consumer handshake and status bundle for fifo_sync.
// master = the side that writes/reads the FIFO, slave = the FIFO itself.
interface fifo_sync_if #(
    parameter int Nb = 8,
    parameter int M  = 2
) ();

    logic          flush;
    logic          wr_valid;
    logic [Nb-1:0] wr_data;
    logic          wr_ready;
    logic          rd_ready;
    logic          rd_valid;
    logic [Nb-1:0] rd_data;
    logic [M:0]    count;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic [M:0]    high_water;

    modport master (
        output flush, wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, count,
               almost_full, almost_empty, overflow, high_water
    );

    modport slave (
        input  flush, wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, count,
               almost_full, almost_empty, overflow, high_water
    );

endinterface

// File: rtl/fifo_sync_mem.sv
// FIFO storage: 2**M x Nb register array, synchronous write, asynchronous read.
module fifo_sync_mem #(
    parameter int Nb = 8,
    parameter int M  = 2
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [M-1:0]  wr_addr,
    input  logic [Nb-1:0] wr_data,
    input  logic [M-1:0]  rd_addr,
    output logic [Nb-1:0] rd_data
);

    logic [Nb-1:0] mem [0:(1<<M)-1];

    // Store the incoming word at the write address.
    // NOTE: the array has no reset; a word is only ever observed after it has
    // been written, because the control logic gates reads on count != 0.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with selectable read mode (registered or first-word-fall-through),
// almost-full/empty thresholds, synchronous flush, sticky overflow and high-water mark.
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int Nb        = 8,
    parameter int M         = 2,
    parameter int FWFT      = FIFO_MODE_STD,
    parameter int AF_THRESH = (1 << M) - 1,
    parameter int AE_THRESH = 1
) (
    input logic        clk,
    input logic        reset,
    fifo_sync_if.slave bus
);

    localparam int         N     = 1 << M;
    localparam int         AW    = clog2(N);
    localparam logic [M:0] DEPTH = N[M:0];
    localparam logic [M:0] AF_T  = AF_THRESH[M:0];
    localparam logic [M:0] AE_T  = AE_THRESH[M:0];

    logic [M:0]    wr_ptr;
    logic [M:0]    rd_ptr;
    logic [M:0]    count;
    logic [M:0]    count_next;
    logic [M:0]    high_water;
    logic          overflow;
    logic          push;
    logic          pop;
    logic [Nb-1:0] mem_rdata;

    // Full FIFO refuses writes outright, even if a pop happens the same cycle.
    assign bus.wr_ready = (count != DEPTH);
    assign push         = bus.wr_valid & bus.wr_ready & ~bus.flush;

    fifo_sync_mem #(
        .Nb (Nb),
        .M  (M)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (bus.wr_data),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (mem_rdata)
    );

    // Next occupancy: simultaneous push and pop leave the count unchanged.
    // NOTE: the default assignment comes first so every path drives count_next
    // and no latch is inferred.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    // Pointers, occupancy, sticky overflow and high-water mark; flush outranks push/pop.
    // NOTE: all state here uses non-blocking assignments so every register samples
    // the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            high_water <= '0;
            overflow   <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            high_water <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_next;
            overflow <= overflow | (bus.wr_valid & ~bus.wr_ready);
            if (count_next > high_water) begin
                high_water <= count_next;
            end
        end
    end

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Head word is presented combinationally; the consumer pops by accepting it.
            assign bus.rd_valid = (count != '0);
            assign bus.rd_data  = mem_rdata;
            assign pop          = bus.rd_ready & bus.rd_valid;
        end else begin : g_std
            logic          rd_valid_q;
            logic [Nb-1:0] rd_data_q;

            assign pop = bus.rd_ready & (count != '0);

            // Registered read: a request loads the head word on the next edge.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_valid_q <= 1'b0;
                    rd_data_q  <= '0;
                end else if (bus.flush) begin
                    rd_valid_q <= 1'b0;
                end else if (bus.rd_ready) begin
                    rd_valid_q <= (count != '0);
                    if (count != '0) begin
                        rd_data_q <= mem_rdata;
                    end
                end
            end

            assign bus.rd_valid = rd_valid_q;
            assign bus.rd_data  = rd_data_q;
        end
    endgenerate

    assign bus.count        = count;
    assign bus.almost_full  = (count >= AF_T);
    assign bus.almost_empty = (count <= AE_T);
    assign bus.overflow     = overflow;
    assign bus.high_water   = high_water;

endmodule

// File: tb/tb_fifo_sync.sv
// Directed self-checking bench for fifo_sync: one STD and one FWFT instance, M=2,
// data ordering tracked by per-instance scoreboard queues and a bench-side occupancy model.
module tb_fifo_sync;
    import fifo_pkg::*;

    logic clk = 1'b0;
    logic reset;

    fifo_sync_if #(.Nb(8), .M(2)) s_if ();
    fifo_sync_if #(.Nb(8), .M(2)) f_if ();

    fifo_sync #(.Nb(8), .M(2), .FWFT(FIFO_MODE_STD), .AF_THRESH(3), .AE_THRESH(1)) u_std (
        .clk   (clk),
        .reset (reset),
        .bus   (s_if)
    );

    fifo_sync #(.Nb(8), .M(2), .FWFT(FIFO_MODE_FWFT), .AF_THRESH(3), .AE_THRESH(1)) u_fwft (
        .clk   (clk),
        .reset (reset),
        .bus   (f_if)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] sb_s[$];
    logic [7:0] sb_f[$];
    int         s_cnt = 0;
    int         f_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic s_status(input string tag);
        check({tag, "/count"}, s_if.count, s_cnt);
        check({tag, "/wr_ready"}, s_if.wr_ready, (s_cnt != 4));
        check({tag, "/almost_empty"}, s_if.almost_empty, (s_cnt <= 1));
        check({tag, "/almost_full"}, s_if.almost_full, (s_cnt >= 3));
    endtask

    task automatic s_write(input logic [7:0] d);
        s_if.wr_valid = 1'b1;
        s_if.wr_data  = d;
        if (s_cnt != 4) begin
            sb_s.push_back(d);
            s_cnt++;
        end
        tick();
        s_if.wr_valid = 1'b0;
    endtask

    task automatic s_read(input string tag);
        logic [7:0] exp;
        s_if.rd_ready = 1'b1;
        tick();
        s_if.rd_ready = 1'b0;
        if (s_cnt != 0) begin
            exp = sb_s.pop_front();
            s_cnt--;
            check({tag, "/rd_valid"}, s_if.rd_valid, 1);
            check({tag, "/rd_data"}, s_if.rd_data, exp);
        end else begin
            check({tag, "/rd_valid"}, s_if.rd_valid, 0);
        end
    endtask

    task automatic f_write(input logic [7:0] d);
        f_if.wr_valid = 1'b1;
        f_if.wr_data  = d;
        if (f_cnt != 4) begin
            sb_f.push_back(d);
            f_cnt++;
        end
        tick();
        f_if.wr_valid = 1'b0;
    endtask

    task automatic f_read(input string tag);
        check({tag, "/rd_valid"}, f_if.rd_valid, (f_cnt != 0));
        if (f_cnt != 0) begin
            check({tag, "/rd_data"}, f_if.rd_data, sb_f[0]);
        end
        f_if.rd_ready = 1'b1;
        tick();
        f_if.rd_ready = 1'b0;
        if (f_cnt != 0) begin
            void'(sb_f.pop_front());
            f_cnt--;
        end
        check({tag, "/count"}, f_if.count, f_cnt);
    endtask

    task automatic s_reset_values(input string tag);
        check({tag, "/count"}, s_if.count, 0);
        check({tag, "/wr_ready"}, s_if.wr_ready, 1);
        check({tag, "/almost_empty"}, s_if.almost_empty, 1);
        check({tag, "/almost_full"}, s_if.almost_full, 0);
        check({tag, "/rd_valid"}, s_if.rd_valid, 0);
        check({tag, "/rd_data"}, s_if.rd_data, 0);
        check({tag, "/overflow"}, s_if.overflow, 0);
        check({tag, "/high_water"}, s_if.high_water, 0);
        check({tag, "/f_count"}, f_if.count, 0);
        check({tag, "/f_rd_valid"}, f_if.rd_valid, 0);
    endtask

    initial begin
        logic [7:0] exp;

        s_if.flush = 1'b0; s_if.wr_valid = 1'b0; s_if.wr_data = '0; s_if.rd_ready = 1'b0;
        f_if.flush = 1'b0; f_if.wr_valid = 1'b0; f_if.wr_data = '0; f_if.rd_ready = 1'b0;
        reset = 1'b1;
        #1;
        s_reset_values("reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Fill the STD FIFO, overflow it, drain it.
        s_write(8'h11); s_write(8'h22); s_write(8'h33); s_write(8'h44);
        s_status("t1_full");
        check("t1_full/high_water", s_if.high_water, 4);
        s_write(8'h55);
        check("t1_ovf/overflow", s_if.overflow, 1);
        check("t1_ovf/count", s_if.count, 4);
        for (int i = 0; i < 4; i++) s_read("t1_rd");
        s_status("t1_drained");
        s_read("t1_empty_rd");
        check("t1_empty_rd/rd_data_hold", s_if.rd_data, 8'h44);

        // Flush with a concurrent write clears contents, overflow and high-water mark.
        s_write(8'hA1); s_write(8'hA2); s_write(8'hA3); s_write(8'hA4);
        s_read("t4_pre");
        check("t4_pre/overflow_sticky", s_if.overflow, 1);
        check("t4_pre/count", s_if.count, 3);
        s_if.flush    = 1'b1;
        s_if.wr_valid = 1'b1;
        s_if.wr_data  = 8'h99;
        tick();
        s_if.flush    = 1'b0;
        s_if.wr_valid = 1'b0;
        sb_s.delete();
        s_cnt = 0;
        check("t4_flush/count", s_if.count, 0);
        check("t4_flush/overflow", s_if.overflow, 0);
        check("t4_flush/high_water", s_if.high_water, 0);
        check("t4_flush/rd_valid", s_if.rd_valid, 0);
        check("t4_flush/rd_data_hold", s_if.rd_data, 8'hA1);
        tick();
        check("t4_after/count", s_if.count, 0);
        s_read("t4_empty_rd");

        // Simultaneous push/pop at count 2 across pointer wrap.
        s_write(8'hB0); s_write(8'hB1);
        check("t3_pre/high_water", s_if.high_water, 2);
        for (int i = 0; i < 10; i++) begin
            s_if.wr_valid = 1'b1;
            s_if.wr_data  = 8'hC0 + 8'(i);
            s_if.rd_ready = 1'b1;
            sb_s.push_back(8'hC0 + 8'(i));
            exp = sb_s.pop_front();
            tick();
            check("t3_stream/rd_valid", s_if.rd_valid, 1);
            check("t3_stream/rd_data", s_if.rd_data, exp);
            check("t3_stream/count", s_if.count, 2);
        end
        s_if.wr_valid = 1'b0;
        s_if.rd_ready = 1'b0;
        check("t3_post/high_water", s_if.high_water, 2);
        s_read("t3_drain"); s_read("t3_drain");

        // Threshold sweep 0..4..0.
        s_status("t6_c0");
        for (int i = 0; i < 4; i++) begin
            s_write(8'hD0 + 8'(i));
            s_status("t6_up");
        end
        for (int i = 0; i < 4; i++) begin
            s_read("t6_rd");
            s_status("t6_down");
        end

        // FWFT: zero-latency head word, hold while not accepted, pop on accept.
        f_write(8'hA5);
        check("t2_vis/rd_valid", f_if.rd_valid, 1);
        check("t2_vis/rd_data", f_if.rd_data, 8'hA5);
        check("t2_vis/count", f_if.count, 1);
        tick();
        check("t2_hold/rd_valid", f_if.rd_valid, 1);
        check("t2_hold/rd_data", f_if.rd_data, 8'hA5);
        f_read("t2_pop");
        check("t2_pop/rd_valid_after", f_if.rd_valid, 0);
        f_write(8'hE1); f_write(8'hE2);
        f_read("t2_seq"); f_read("t2_seq");
        f_read("t2_empty");

        // Asynchronous reset mid-burst.
        s_write(8'h31); s_write(8'h32); s_write(8'h33);
        check("t5_pre/count", s_if.count, 3);
        f_write(8'h41);
        s_if.wr_valid = 1'b1;
        s_if.wr_data  = 8'h34;
        #2;
        reset = 1'b1;
        #1;
        s_reset_values("t5_async");
        tick();
        check("t5_held/count", s_if.count, 0);
        s_if.wr_valid = 1'b0;
        reset = 1'b0;
        sb_s.delete(); s_cnt = 0;
        sb_f.delete(); f_cnt = 0;
        s_read("t5_empty_rd");
        check("t5_empty_rd/rd_data", s_if.rd_data, 0);
        check("t5_empty_rd/count", s_if.count, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
